// File: rtl/dmac_ch_arbiter.sv
// Round-robin owner of the shared AHB master: grants one DMA channel
// at a time, rotates at burst boundaries, gathers completion status.
module dmac_ch_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int QUANTUM = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         dma_req,
  input  logic [NUM_CH-1:0]         ch_ready,
  input  logic [NUM_CH-1:0]         burst_done,
  input  logic [NUM_CH-1:0]         ch_irq,
  input  logic                      bus_idle,
  input  logic [NUM_CH-1:0]         irq_clr,
  output logic [NUM_CH-1:0]         grant,
  output logic [$clog2(NUM_CH)-1:0] grant_id,
  output logic                      busy,
  output logic [NUM_CH-1:0]         dma_ack,
  output logic [NUM_CH-1:0]         irq_status,
  output logic                      irq
);

  localparam int          IW = $clog2(NUM_CH);
  localparam logic [3:0]  QW = 4'(QUANTUM);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_GRANT,
    S_SWITCH
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_CH-1:0]   r_grant;
  logic [IW-1:0]       r_grant_id;
  logic [IW-1:0]       r_rr_ptr;
  logic [3:0]          r_burst_cnt;
  logic [NUM_CH-1:0]   r_dma_ack;
  logic [NUM_CH-1:0]   r_irq_status;
  logic                r_irq;

  logic [NUM_CH-1:0]   w_grant_nxt;
  logic [IW-1:0]       w_gid_nxt;
  logic [IW-1:0]       w_rr_nxt;
  logic [3:0]          w_cnt_nxt;
  logic [NUM_CH-1:0]   w_ack_nxt;
  logic [NUM_CH-1:0]   w_set;
  logic [NUM_CH-1:0]   w_status_nxt;

  logic [NUM_CH-1:0]   w_elig;
  logic [NUM_CH-1:0]   w_others;
  logic                w_any;
  logic                w_found;
  logic [IW-1:0]       w_win;
  logic [NUM_CH-1:0]   w_win_oh;
  int                  w_idx;
  logic                w_g_rdy;
  logic                w_g_req;
  logic                w_g_done;
  logic                w_g_irq;
  logic [3:0]          w_cnt_inc;
  logic                w_quant;

  assign w_elig    = dma_req & ch_ready;
  assign w_any     = |w_elig;
  assign w_others  = w_elig & ~r_grant;
  assign w_g_rdy   = ch_ready[r_grant_id];
  assign w_g_req   = dma_req[r_grant_id];
  assign w_g_done  = burst_done[r_grant_id];
  assign w_g_irq   = ch_irq[r_grant_id];
  assign w_cnt_inc = (r_burst_cnt == 4'd15) ? 4'd15 : r_burst_cnt + 4'd1;
  assign w_quant   = (w_cnt_inc >= QW);
  assign w_win_oh  = {{(NUM_CH-1){1'b0}}, 1'b1} << w_win;

  // Search starts just past the last winner so every channel gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_CH;
      if (!w_found && w_elig[IW'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = IW'(w_idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gid_nxt   = r_grant_id;
    w_rr_nxt    = r_rr_ptr;
    w_cnt_nxt   = r_burst_cnt;
    w_ack_nxt   = '0;
    w_set       = '0;
    unique case (r_state)
      S_IDLE: begin
        w_grant_nxt = '0;
        if (w_any) w_state_nxt = S_ARB;
      end
      S_ARB: begin
        w_grant_nxt = '0;
        w_state_nxt = S_IDLE;
        if (w_found) begin
          w_grant_nxt = w_win_oh;
          w_gid_nxt   = w_win;
          w_rr_nxt    = w_win;
          w_cnt_nxt   = '0;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!w_g_rdy) begin
          w_grant_nxt = '0;
          w_state_nxt = S_SWITCH;
        end else if (w_g_irq) begin
          w_grant_nxt = '0;
          w_set       = r_grant;
          w_ack_nxt   = r_grant;
          w_state_nxt = S_SWITCH;
        end else if (w_g_done) begin
          w_cnt_nxt = w_quant ? 4'd0 : w_cnt_inc;
          if (!w_g_req || (w_quant && |w_others)) begin
            w_cnt_nxt   = w_cnt_inc;
            w_grant_nxt = '0;
            w_state_nxt = S_SWITCH;
          end
        end
      end
      S_SWITCH: begin
        w_grant_nxt = '0;
        if (bus_idle) w_state_nxt = w_any ? S_ARB : S_IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // A completion set in the same cycle as a clear must survive.
  assign w_status_nxt = (r_irq_status & ~irq_clr) | w_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant      <= '0;
      r_grant_id   <= '0;
      r_rr_ptr     <= IW'(NUM_CH - 1);
      r_burst_cnt  <= '0;
      r_dma_ack    <= '0;
      r_irq_status <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_grant      <= w_grant_nxt;
      r_grant_id   <= w_gid_nxt;
      r_rr_ptr     <= w_rr_nxt;
      r_burst_cnt  <= w_cnt_nxt;
      r_dma_ack    <= w_ack_nxt;
      r_irq_status <= w_status_nxt;
      r_irq        <= |w_status_nxt;
    end
  end

  assign grant      = r_grant;
  assign grant_id   = r_grant_id;
  assign busy       = (r_state != S_IDLE);
  assign dma_ack    = r_dma_ack;
  assign irq_status = r_irq_status;
  assign irq        = r_irq;

endmodule

// File: tb/tb_dmac_ch_arbiter.sv
// Bench for dmac_ch_arbiter: directed scenarios plus random traffic,
// two instances (quantum 1 and 2) checked against a reference model.
module tb_dmac_ch_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dma_req, ch_ready, burst_done, ch_irq, irq_clr;
  logic       bus_idle;

  logic [3:0] g1, a1, s1;
  logic [1:0] id1;
  logic       b1, q1;
  logic [3:0] g2, a2, s2;
  logic [1:0] id2;
  logic       b2, q2;

  always #5 clk = ~clk;

  dmac_ch_arbiter #(.NUM_CH(4), .QUANTUM(1)) u_q1 (
    .clk(clk), .rst(rst), .dma_req(dma_req), .ch_ready(ch_ready),
    .burst_done(burst_done), .ch_irq(ch_irq), .bus_idle(bus_idle),
    .irq_clr(irq_clr), .grant(g1), .grant_id(id1), .busy(b1),
    .dma_ack(a1), .irq_status(s1), .irq(q1)
  );

  dmac_ch_arbiter #(.NUM_CH(4), .QUANTUM(2)) u_q2 (
    .clk(clk), .rst(rst), .dma_req(dma_req), .ch_ready(ch_ready),
    .burst_done(burst_done), .ch_irq(ch_irq), .bus_idle(bus_idle),
    .irq_clr(irq_clr), .grant(g2), .grant_id(id2), .busy(b2),
    .dma_ack(a2), .irq_status(s2), .irq(q2)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ph: 0 nothing owned, 1 choosing, 2 owner holds bus, 3 draining
  typedef struct {
    int         q;
    int         ph;
    int         own;
    int         rr;
    int         cnt;
    logic [3:0] st;
    logic [3:0] ack;
    logic       irq;
  } mdl_t;

  mdl_t m[2];

  function automatic mdl_t mreset(int q);
    mdl_t n;
    n.q = q; n.ph = 0; n.own = 0; n.rr = 3; n.cnt = 0;
    n.st = '0; n.ack = '0; n.irq = 1'b0;
    return n;
  endfunction

  function automatic mdl_t step(mdl_t m0, logic [3:0] req,
                                logic [3:0] rdy, logic [3:0] bd,
                                logic [3:0] ci, logic [3:0] clr,
                                logic bi);
    mdl_t       n = m0;
    logic [3:0] el = req & rdy;
    logic [3:0] gm = 4'(1 << m0.own);
    int         c;
    n.ack = '0;
    n.st  = m0.st & ~clr;
    case (m0.ph)
      0: if (el != 0) n.ph = 1;
      1: begin
        n.ph = 0;
        for (int k = 1; k <= 4; k++) begin
          int i = (m0.rr + k) % 4;
          if (n.ph == 0 && el[i]) begin
            n.ph = 2; n.own = i; n.rr = i; n.cnt = 0;
          end
        end
      end
      2: begin
        if (!rdy[m0.own]) n.ph = 3;
        else if (ci[m0.own]) begin
          n.ph = 3; n.st = n.st | gm; n.ack = gm;
        end else if (bd[m0.own]) begin
          c = (m0.cnt < 15) ? m0.cnt + 1 : 15;
          if (!req[m0.own] || (c >= m0.q && (el & ~gm) != 0)) begin
            n.ph = 3; n.cnt = c;
          end else n.cnt = (c >= m0.q) ? 0 : c;
        end
      end
      3: if (bi) n.ph = (el != 0) ? 1 : 0;
      default: n.ph = 0;
    endcase
    n.irq = |n.st;
    return n;
  endfunction

  task automatic cmp(string d, mdl_t e, logic [3:0] g, logic [1:0] id,
                     logic b, logic [3:0] a, logic [3:0] s, logic q);
    chk({d, ".grant"}, 32'(g), (e.ph == 2) ? (32'd1 << e.own) : 32'd0);
    chk({d, ".id"},    32'(id), 32'(e.own));
    chk({d, ".busy"},  32'(b),  32'(e.ph != 0));
    chk({d, ".ack"},   32'(a),  32'(e.ack));
    chk({d, ".st"},    32'(s),  32'(e.st));
    chk({d, ".irq"},   32'(q),  32'(e.irq));
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) m[i] = mreset(i + 1);
      else m[i] = step(m[i], dma_req, ch_ready, burst_done, ch_irq,
                       irq_clr, bus_idle);
    end
    @(negedge clk);
    cmp("q1", m[0], g1, id1, b1, a1, s1, q1);
    cmp("q2", m[1], g2, id2, b2, a2, s2, q2);
  endtask

  task automatic clr_in();
    dma_req = '0; ch_ready = '0; burst_done = '0;
    ch_irq = '0; irq_clr = '0; bus_idle = 1'b1;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(int which);
    int n = 0;
    while (((which == 0) ? g1 : g2) == 4'd0 && n < 20) begin
      tick();
      n++;
    end
    chk("wait_gnt", 32'(((which == 0) ? g1 : g2) != 4'd0), 32'd1);
  endtask

  int exp_ord[4] = '{0, 1, 3, 0};

  initial begin
    m[0] = mreset(1);
    m[1] = mreset(2);
    clr_in();
    rst = 1'b1;
    @(negedge clk);
    do_reset();
    chk("rst_grant", 32'(g1), 32'd0);
    chk("rst_id",    32'(id1), 32'd0);
    chk("rst_busy",  32'(b1), 32'd0);
    chk("rst_irq",   32'(q1), 32'd0);

    // single request, completion
    dma_req = 4'b0100; ch_ready = 4'b0100;
    tick();
    chk("t1_arb", 32'(g1), 32'd0);
    tick();
    chk("t1_grant", 32'(g1), 32'b0100);
    chk("t1_id", 32'(id1), 32'd2);
    ch_irq = 4'b0100; dma_req = '0;
    tick();
    ch_irq = '0;
    chk("t1_drop", 32'(g1), 32'd0);
    chk("t1_ack", 32'(a1), 32'b0100);
    chk("t1_st", 32'(s1), 32'b0100);
    chk("t1_irq", 32'(q1), 32'd1);
    tick();
    chk("t1_ack_pulse", 32'(a1), 32'd0);

    // rotation, quantum 1
    do_reset();
    dma_req = 4'b1011; ch_ready = 4'b1011;
    wait_grant(0);
    for (int r = 0; r < 4; r++) begin
      int n;
      chk("rot_id", 32'(id1), 32'(exp_ord[r]));
      burst_done = g1;
      tick();
      burst_done = '0;
      n = 1;
      while (g1 == 4'd0 && n < 20) begin
        tick();
        n++;
      end
      chk("rot_lat", 32'(n), 32'd3);
    end

    // quantum hold on the QUANTUM=2 instance
    do_reset();
    dma_req = 4'b0011; ch_ready = 4'b0011;
    wait_grant(1);
    chk("q_id", 32'(id2), 32'd0);
    burst_done = 4'b0001;
    tick();
    burst_done = '0;
    chk("q_hold", 32'(g2), 32'b0001);
    tick();
    burst_done = 4'b0001;
    tick();
    burst_done = '0;
    chk("q_rel", 32'(g2), 32'd0);
    wait_grant(1);
    chk("q_next", 32'(id2), 32'd1);

    // bus stall in switch
    do_reset();
    dma_req = 4'b0011; ch_ready = 4'b0011;
    wait_grant(0);
    bus_idle = 1'b0;
    burst_done = 4'b0001;
    tick();
    burst_done = '0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_nogrant", 32'(g1), 32'd0);
      if (k < 4) tick();
    end
    bus_idle = 1'b1;
    tick();
    chk("stall_arb", 32'(g1), 32'd0);
    tick();
    chk("stall_grant", 32'(g1), 32'b0010);

    // simultaneous events
    do_reset();
    dma_req = 4'b0100; ch_ready = 4'b0100;
    wait_grant(0);
    ch_irq = 4'b0100; burst_done = 4'b0100;
    tick();
    ch_irq = '0; burst_done = '0;
    chk("sim_ack", 32'(a1), 32'b0100);
    chk("sim_st", 32'(s1), 32'b0100);
    wait_grant(0);
    ch_irq = 4'b0100; irq_clr = 4'b0100;
    tick();
    ch_irq = '0; irq_clr = '0;
    chk("set_wins", 32'(s1), 32'b0100);
    irq_clr = 4'b0011;
    tick();
    chk("clr_noop", 32'(s1), 32'b0100);
    irq_clr = 4'b0100;
    tick();
    irq_clr = '0;
    chk("clr_st", 32'(s1), 32'd0);
    chk("clr_irq", 32'(q1), 32'd0);

    // abort, then async reset mid-grant
    do_reset();
    dma_req = 4'b0100; ch_ready = 4'b0100;
    wait_grant(0);
    ch_ready = '0;
    tick();
    chk("abort_grant", 32'(g1), 32'd0);
    chk("abort_st", 32'(s1), 32'd0);
    ch_ready = 4'b0100;
    wait_grant(0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_grant", 32'(g1), 32'd0);
    chk("arst_id", 32'(id1), 32'd0);
    chk("arst_busy", 32'(b1), 32'd0);
    chk("arst_grant2", 32'(g2), 32'd0);
    tick();
    rst = 1'b0;
    dma_req = 4'hF; ch_ready = 4'hF;
    wait_grant(0);
    chk("arst_first", 32'(id1), 32'd0);

    // random traffic
    do_reset();
    dma_req = 4'hF; ch_ready = 4'hF;
    for (int c = 0; c < 3000; c++) begin
      dma_req  ^= ($urandom_range(0, 7) == 0) ?
                  4'(1 << $urandom_range(0, 3)) : 4'd0;
      ch_ready ^= ($urandom_range(0, 11) == 0) ?
                  4'(1 << $urandom_range(0, 3)) : 4'd0;
      burst_done = 4'($urandom) & 4'($urandom);
      ch_irq   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0;
      irq_clr  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
      bus_idle = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
